ram_read_realigner: RTL
=======================

RAM_READ_REALIGNER -- requirements
Module: ram_read_realigner

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, byte-address width; word index width is ADDR_W-2.
REQ-002 SHALL have parameter RD_LATENCY, default 1, sub-RAM read latency in cycles; legal values are 1 and 2.
REQ-003 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1: read request handshake.
REQ-006 SHALL have ports req_addr in ADDR_W, req_size in 2 (00 byte, 01 half, 10/11 word), req_signed in 1.
REQ-007 SHALL have ports lane_addr_0..lane_addr_3 out ADDR_W-2: per-byte-lane word index.
REQ-008 SHALL have ports lane_rden out 1 (common read enable) and lane_q_0..lane_q_3 in 8 (lane read data).
REQ-009 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out 32: response handshake.

Function
REQ-010 Lane i SHALL hold the byte whose address satisfies addr[1:0]==i; this is the read-side inverse of the write-path lane rotation.
REQ-011 FSM states: IDLE, ISSUE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-012 IDLE->ISSUE on req_valid&&req_ready; req_addr, req_size and req_signed SHALL be captured on that edge.
REQ-013 In ISSUE, for offset o=addr[1:0] and base=addr[ADDR_W-1:2], lane_addr_i SHALL equal base+1 when i<o, else base.
REQ-014 base+1 SHALL wrap modulo 2^(ADDR_W-2): 0xFFFF+1 -> 0x0000 at the default width.
REQ-015 lane_rden SHALL be 1 for exactly the ISSUE cycle; lane_addr_* SHALL hold their values until the next ISSUE.
REQ-016 ISSUE->WAIT unconditionally; WAIT SHALL last RD_LATENCY cycles, with a down-counter, and lane_q_* SHALL be sampled on its final edge.
REQ-017 Result byte k SHALL equal lane_q_((o+k) mod 4), i.e. a right rotation by o lanes.
REQ-018 Size rule: byte -> bits[31:8] extended from byte 0; half -> bits[31:16] extended from byte 1; word -> all four bytes.
REQ-019 WAIT->RESP: rsp_valid SHALL be 1 and rsp_data SHALL be stable for the whole RESP state.
REQ-020 RESP->IDLE on rsp_valid&&rsp_ready; with no new request accepted, rsp_valid SHALL be 0 on the next cycle.
REQ-021 Latency: with handshake at cycle T, rsp_valid SHALL first be 1 at cycle T+2+RD_LATENCY.
REQ-022 Only one request SHALL be outstanding; req_valid outside IDLE SHALL be ignored and not queued.
REQ-023 Unaligned accesses spanning two words SHALL complete in a single ISSUE, via the per-lane addresses.

Reset
REQ-024 While rst==0 at a clock edge, the following SHALL hold on the next cycle: state IDLE, rsp_valid 0, rsp_data 0, lane_rden 0, lane_addr_* 0, WAIT counter 0.
REQ-025 req_ready SHALL be 0 during reset and 1 on the first cycle after rst returns to 1.
REQ-026 Reset in ISSUE, WAIT or RESP SHALL abandon the request; no rsp_valid pulse SHALL follow, and late lane_q data SHALL be ignored.

Configuration
REQ-027 With macro RD_SIGN_EXT_EN defined, the extension bits SHALL replicate the MSB of the top kept byte when req_signed==1, and be 0 otherwise.
REQ-028 Without RD_SIGN_EXT_EN, req_signed SHALL be ignored and extension SHALL always be zero; the port SHALL remain present.

Verification
Preload for REQ-029..REQ-032: word0=0x44332211, word1=0x88776655, RD_LATENCY=1.
REQ-029 Word read at addr 0x0 -> all lane_addr=0, rden pulses at T+1, rsp_valid at T+3, rsp_data=0x44332211.
REQ-030 Word read at addr 0x1 -> lane_addr {0:1,1:0,2:0,3:0}, rsp_data=0x55443322.
REQ-031 Half read at addr 0x3 -> rsp_data=0x00005544; signed byte read at addr 0x7 -> 0xFFFFFF88 with RD_SIGN_EXT_EN, 0x00000088 without.
REQ-032 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid stays 1, rsp_data stays constant, req_ready stays 0, a concurrent req_valid is dropped.
REQ-033 Word read at addr 0x3FFFE -> lane_addr {0:0x0000,1:0x0000,2:0xFFFF,3:0xFFFF}; with word 0xFFFF=0xDDCCBBAA and word 0=0x44332211, rsp_data=0x2211DDCC.
REQ-034 rst=0 for one cycle during WAIT -> no rsp_valid ever pulses, req_ready=1 after release, and a following word read at addr 0x4 returns 0x88776655.

Source files
------------

// File: rtl/ram_read_realigner.sv
// Read-side byte-lane realigner: one issue per request, rotates lane data back into address order.
// Optional macro RD_SIGN_EXT_EN enables sign extension of byte/half results when req_signed is set.
module ram_read_realigner #(
  parameter int ADDR_W     = 18,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic [ADDR_W-3:0] lane_addr_0,
  output logic [ADDR_W-3:0] lane_addr_1,
  output logic [ADDR_W-3:0] lane_addr_2,
  output logic [ADDR_W-3:0] lane_addr_3,
  output logic              lane_rden,
  input  logic [7:0]        lane_q_0,
  input  logic [7:0]        lane_q_1,
  input  logic [7:0]        lane_q_2,
  input  logic [7:0]        lane_q_3,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data
);

  localparam int WW = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [1:0]      off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic [WW-1:0]   lane_addr_q [4];
  logic [WW-1:0]   lane_addr_d [4];
  logic [31:0]     rsp_data_q, rsp_data_d;

  logic [7:0]      lane_q [4];
  logic [WW-1:0]   base, base_inc;
  logic [31:0]     rot, fmt;
  logic            ext_b, ext_h;

  assign lane_q[0] = lane_q_0;
  assign lane_q[1] = lane_q_1;
  assign lane_q[2] = lane_q_2;
  assign lane_q[3] = lane_q_3;

  assign lane_addr_0 = lane_addr_q[0];
  assign lane_addr_1 = lane_addr_q[1];
  assign lane_addr_2 = lane_addr_q[2];
  assign lane_addr_3 = lane_addr_q[3];
  assign rsp_data    = rsp_data_q;

`ifdef RD_SIGN_EXT_EN
  logic signed_q, signed_d;
  assign ext_b = signed_q & rot[7];
  assign ext_h = signed_q & rot[15];
`else
  logic unused_signed;
  assign unused_signed = req_signed;
  assign ext_b = 1'b0;
  assign ext_h = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    off_d      = off_q;
    size_d     = size_q;
    lane_addr_d = lane_addr_q;
    rsp_data_d = rsp_data_q;
`ifdef RD_SIGN_EXT_EN
    signed_d   = signed_q;
`endif
    req_ready  = 1'b0;
    lane_rden  = 1'b0;
    rsp_valid  = 1'b0;
    base       = req_addr[ADDR_W-1:2];
    base_inc   = base + WW'(1);

    // Byte k of the result comes from the lane holding address base+o+k.
    rot = '0;
    for (int k = 0; k < 4; k++) begin
      rot[8*k +: 8] = lane_q[off_q + 2'(k)];
    end

    case (size_q)
      2'b00:   fmt = {{24{ext_b}}, rot[7:0]};
      2'b01:   fmt = {{16{ext_h}}, rot[15:0]};
      default: fmt = rot;
    endcase

    unique case (state_q)
      IDLE: begin
        req_ready = rst;
        if (req_valid && rst) begin
          off_d  = req_addr[1:0];
          size_d = req_size;
`ifdef RD_SIGN_EXT_EN
          signed_d = req_signed;
`endif
          // Lanes below the offset belong to the following word.
          for (int i = 0; i < 4; i++) begin
            lane_addr_d[i] = (2'(i) < req_addr[1:0]) ? base_inc : base;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lane_rden = 1'b1;
        cnt_d     = 2'(RD_LATENCY - 1);
        state_d   = WAIT;
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          rsp_data_d = fmt;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      off_q      <= 2'd0;
      size_q     <= 2'd0;
      rsp_data_q <= 32'd0;
      for (int i = 0; i < 4; i++) lane_addr_q[i] <= '0;
`ifdef RD_SIGN_EXT_EN
      signed_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      off_q      <= off_d;
      size_q     <= size_d;
      rsp_data_q <= rsp_data_d;
      for (int i = 0; i < 4; i++) lane_addr_q[i] <= lane_addr_d[i];
`ifdef RD_SIGN_EXT_EN
      signed_q   <= signed_d;
`endif
    end
  end

endmodule
